// File: rtl/ret_pop_sequencer.sv
// RET pop sequencer: reads a 16-bit return address from the stack (low byte first),
// then loads PC and SP. Optional conditional returns (11ccc000) enabled by `define CONDRET_EN.
module ret_pop_sequencer (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  Source,
  input  logic        flag_true,
  input  logic [15:0] sp_in,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ready,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic [15:0] pc_out,
  output logic        pc_load,
  output logic [15:0] sp_out,
  output logic        sp_write,
  output logic [4:0]  _decodedXPT,
  output logic        busy,
  output logic        done
);

  // State codes double as the externally visible step number.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_LOW  = 3'd4,
    RD_HIGH = 3'd5,
    LOAD    = 3'd6,
    SKIP    = 3'd7
  } state_t;

  state_t      state;
  logic [15:0] sp;
  logic [15:0] sp_inc;
  logic        is_ret;
  logic        go_pop;
  logic        go_skip;

  assign sp_inc = sp + 16'd1;
  assign is_ret = (Source == 8'hC9);

`ifdef CONDRET_EN
  logic is_cond;
  assign is_cond = (Source[7:6] == 2'b11) && (Source[2:0] == 3'b000);
  assign go_pop  = start && (is_ret || (is_cond && flag_true));
  assign go_skip = start && is_cond && !flag_true;
`else
  logic unused_flag;
  assign unused_flag = flag_true;
  assign go_pop  = start && is_ret;
  assign go_skip = 1'b0;
`endif

  assign _decodedXPT = {2'b00, state};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      sp       <= 16'h0000;
      mem_addr <= 16'h0000;
      mem_rd   <= 1'b0;
      pc_out   <= 16'h0000;
      pc_load  <= 1'b0;
      sp_out   <= 16'h0000;
      sp_write <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      pc_load  <= 1'b0;
      sp_write <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (go_pop) begin
            sp       <= sp_in;
            mem_addr <= sp_in;
            mem_rd   <= 1'b1;
            busy     <= 1'b1;
            state    <= RD_LOW;
          end else if (go_skip) begin
            done  <= 1'b1;
            busy  <= 1'b1;
            state <= SKIP;
          end
        end
        RD_LOW: begin
          if (mem_ready) begin
            pc_out[7:0] <= mem_rdata;
            sp          <= sp_inc;
            mem_addr    <= sp_inc;
            state       <= RD_HIGH;
          end
        end
        RD_HIGH: begin
          // mem_addr keeps the last read address once the reads are over.
          if (mem_ready) begin
            pc_out[15:8] <= mem_rdata;
            sp           <= sp_inc;
            sp_out       <= sp_inc;
            mem_rd       <= 1'b0;
            pc_load      <= 1'b1;
            sp_write     <= 1'b1;
            done         <= 1'b1;
            state        <= LOAD;
          end
        end
        LOAD, SKIP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          mem_rd <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ret_pop_sequencer.sv
// Directed bench for ret_pop_sequencer: byte-wide memory model, assertions at each check point.
module tb_ret_pop_sequencer;

  logic        clock;
  logic        reset;
  logic        start;
  logic [7:0]  Source;
  logic        flag_true;
  logic [15:0] sp_in;
  logic [7:0]  mem_rdata;
  logic        mem_ready;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [15:0] pc_out;
  logic        pc_load;
  logic [15:0] sp_out;
  logic        sp_write;
  logic [4:0]  _decodedXPT;
  logic        busy;
  logic        done;

  logic [7:0] mem [0:65535];
  int checks;
  int errors;

  ret_pop_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .Source(Source),
    .flag_true(flag_true), .sp_in(sp_in), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .pc_out(pc_out), .pc_load(pc_load), .sp_out(sp_out), .sp_write(sp_write),
    ._decodedXPT(_decodedXPT), .busy(busy), .done(done)
  );

  assign mem_rdata = mem[mem_addr];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  // All outputs packed so one comparison covers the cleared/idle picture.
  function automatic logic [31:0] strobes();
    return {24'h0, _decodedXPT, mem_rd, pc_load, sp_write, busy, done} >> 0;
  endfunction

  task automatic launch(input logic [7:0] op, input logic flag, input logic [15:0] sp);
    Source = op; flag_true = flag; sp_in = sp; start = 1'b1;
    step();
    start = 1'b0; Source = 8'h00; flag_true = 1'b0;
  endtask

  int dcnt;
  int lcnt;

  initial begin
    checks = 0; errors = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h1FFE] = 8'h34; mem[16'h1FFF] = 8'h12;
    mem[16'hFFFF] = 8'hCD; mem[16'h0000] = 8'hAB;
    reset = 1'b1; start = 1'b0; Source = 8'h00; flag_true = 1'b0;
    sp_in = 16'h0000; mem_ready = 1'b1;
    #1;
    chk("reset_strobes", strobes(), 32'h0);
    chk("reset_addr_pc", {mem_addr, pc_out}, 32'h0);
    chk("reset_sp_out", {16'h0, sp_out}, 32'h0);
    step(); step();
    reset = 1'b0;
    step();

    // Basic pop: strobes {xpt[4:0], mem_rd, pc_load, sp_write, busy, done}
    launch(8'hC9, 1'b0, 16'h1FFE);
    chk("basic_c1_strobes", strobes(), {24'h0, 5'd4, 5'b10010});
    chk("basic_c1_addr", {16'h0, mem_addr}, 32'h1FFE);
    step();
    chk("basic_c2_strobes", strobes(), {24'h0, 5'd5, 5'b10010});
    chk("basic_c2_addr", {16'h0, mem_addr}, 32'h1FFF);
    step();
    chk("basic_c3_strobes", strobes(), {24'h0, 5'd6, 5'b01111});
    chk("basic_c3_pc", {16'h0, pc_out}, 32'h1234);
    chk("basic_c3_sp", {16'h0, sp_out}, 32'h2000);
    step();
    chk("basic_idle_strobes", strobes(), 32'h0);
    chk("basic_idle_hold", {pc_out, sp_out}, 32'h1234_2000);

    // Wrap of SP through 0xFFFF
    launch(8'hC9, 1'b0, 16'hFFFF);
    chk("wrap_c1_addr", {16'h0, mem_addr}, 32'hFFFF);
    step();
    chk("wrap_c2_addr", {16'h0, mem_addr}, 32'h0000);
    step();
    chk("wrap_c3_done", {31'h0, done}, 32'h1);
    chk("wrap_c3_pc_sp", {pc_out, sp_out}, 32'hABCD_0001);
    step();

    // Two wait states in RD_LOW
    launch(8'hC9, 1'b0, 16'h1FFE);
    mem_ready = 1'b0;
    step();
    chk("wait_c2_state", {27'h0, _decodedXPT}, 32'd4);
    chk("wait_c2_addr", {16'h0, mem_addr}, 32'h1FFE);
    step();
    chk("wait_c3_state", {27'h0, _decodedXPT}, 32'd4);
    chk("wait_c3_addr", {15'h0, mem_rd, mem_addr}, 32'h1_1FFE);
    mem_ready = 1'b1;
    step();
    chk("wait_c4_state", {27'h0, _decodedXPT}, 32'd5);
    chk("wait_c4_done", {31'h0, done}, 32'h0);
    step();
    chk("wait_c5_done", {30'h0, done, pc_load}, 32'h3);
    chk("wait_c5_pc", {16'h0, pc_out}, 32'h1234);
    step();

    // Start repeated while busy: exactly one done pulse
    launch(8'hC9, 1'b0, 16'h1FFE);
    dcnt = 0;
    step();
    chk("busy_in_rdhigh", {27'h0, _decodedXPT}, 32'd5);
    start = 1'b1; Source = 8'hC9; sp_in = 16'h0100;
    for (int i = 0; i < 6; i++) begin
      if (done) dcnt++;
      step();
      if (i == 1) begin start = 1'b0; Source = 8'h00; end
    end
    chk("busy_one_done", dcnt, 32'd1);
    chk("busy_idle_after", strobes(), 32'h0);

    // Opcodes that must not start a pop
    Source = 8'h00; start = 1'b1;
    step();
    start = 1'b0;
    chk("opcode_00_ignored", strobes(), 32'h0);
`ifndef CONDRET_EN
    Source = 8'hC0; flag_true = 1'b1; start = 1'b1;
    step();
    start = 1'b0; flag_true = 1'b0;
    chk("opcode_c0_ignored", strobes(), 32'h0);
`endif

    // Reset in RD_HIGH clears everything at once
    launch(8'hC9, 1'b0, 16'h1FFE);
    step();
    chk("rst_pre_state", {27'h0, _decodedXPT}, 32'd5);
    #2 reset = 1'b1;
    #1;
    chk("rst_async_strobes", strobes(), 32'h0);
    chk("rst_async_addr_pc", {mem_addr, pc_out}, 32'h0);
    chk("rst_async_sp", {16'h0, sp_out}, 32'h0);
    step();
    reset = 1'b0;
    lcnt = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (pc_load || sp_write || done) lcnt++;
    end
    chk("rst_no_load_after", lcnt, 32'd0);
    chk("rst_idle_after", strobes(), 32'h0);

`ifdef CONDRET_EN
    // Conditional return, condition false -> SKIP
    launch(8'hC0, 1'b0, 16'h1FFE);
    chk("cond_skip_strobes", strobes(), {24'h0, 5'd7, 5'b00011});
    step();
    chk("cond_skip_idle", strobes(), 32'h0);
    // Conditional return, condition true -> full pop
    launch(8'hC0, 1'b1, 16'h1FFE);
    chk("cond_pop_c1", strobes(), {24'h0, 5'd4, 5'b10010});
    step(); step();
    chk("cond_pop_c3_strobes", strobes(), {24'h0, 5'd6, 5'b01111});
    chk("cond_pop_c3_pc_sp", {pc_out, sp_out}, 32'h1234_2000);
    step();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
